mux_src_pacer: RTL and testbench

- Source-domain (clk_a side) stage that feeds the 4-bit enable-synchronised CDC receiver downstream.
- Accepts words on a valid/ready stream and latches each accepted word onto `data_out`.
- Raises `data_en` for a fixed number of cycles, then holds it low for a fixed gap.
- `data_out` stays stable for the whole window, so the receiver's 2-flop enable synchroniser and rising-edge capture always sample settled data.
- Lives in the clk_a domain; `data_out`/`data_en` connect directly to the receiver's `data_in`/`data_en`.

---
 rtl/mux_cdc_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/mux_src_pacer.sv | 123 ++++++++++++
 tb/tb_mux_src_pacer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_cdc_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mux_cdc_pkg
// Purpose  : Types and constants shared by the mux CDC source and receiver.
// Revision : 1.0 - initial release
// ============================================================================
package mux_cdc_pkg;

    localparam int DEFAULT_DW  = 4;
    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Multi-flop level synchroniser (default two stages), sync reset.
// Revision : 1.0 - initial release
// ============================================================================
module sync_2ff
    import mux_cdc_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mux_src_pacer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mux_src_pacer
// Purpose  : Latches stream words and paces a data_en window for the CDC
//            receiver. Define MUX_SRC_PACER_ACK_EN for the ack_in handshake.
// Revision : 1.0 - initial release
// ============================================================================
module mux_src_pacer
    import mux_cdc_pkg::*;
#(
    parameter int DW       = DEFAULT_DW,
    parameter int HIGH_CYC = 3,
    parameter int GAP_CYC  = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] data_out,
    output logic          data_en,
    output logic          busy
`ifdef MUX_SRC_PACER_ACK_EN
    ,
    input  logic          ack_in
`endif
);

    localparam int CW = $clog2((HIGH_CYC > GAP_CYC) ? HIGH_CYC : GAP_CYC) + 1;
    localparam logic [CW-1:0] C_HIGH_LOAD = CW'(HIGH_CYC - 1);
    localparam logic [CW-1:0] C_GAP_LOAD  = CW'(GAP_CYC - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [DW-1:0]   data_q,  data_d;
    logic            en_q,    en_d;
    logic            w_high_ok;
    logic            w_low_ok;
    logic            w_cnt_zero;

`ifdef MUX_SRC_PACER_ACK_EN
    logic w_ack_sync;

    sync_2ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (ack_in),
        .q_o  (w_ack_sync)
    );

    // Four-phase: leave HIGH once the receiver acks, leave LOW once it releases.
    assign w_high_ok = w_ack_sync;
    assign w_low_ok  = ~w_ack_sync;
`else
    assign w_high_ok = 1'b1;
    assign w_low_ok  = 1'b1;
`endif

    assign w_cnt_zero = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        en_d    = en_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    en_d    = 1'b1;
                    cnt_d   = C_HIGH_LOAD;
                    state_d = HIGH;
                end
            end
            HIGH: begin
                // Counter parks at zero while waiting on the ack condition.
                if (w_cnt_zero && w_high_ok) begin
                    en_d    = 1'b0;
                    cnt_d   = C_GAP_LOAD;
                    state_d = LOW;
                end else if (!w_cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            LOW: begin
                if (w_cnt_zero && w_low_ok) begin
                    state_d = IDLE;
                end else if (!w_cnt_zero) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                en_d    = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign data_out = data_q;
    assign data_en  = en_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_src_pacer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mux_src_pacer
// Purpose  : Self-checking bench for mux_src_pacer (timeline model + directed).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_src_pacer;

    localparam int DW = 4;
    localparam int H  = 3;
    localparam int G  = 3;

    logic          clk      = 1'b0;
    logic          rstn     = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data  = '0;
    logic          in_ready;
    logic [DW-1:0] data_out;
    logic          data_en;
    logic          busy;
`ifdef MUX_SRC_PACER_ACK_EN
    logic          ack_in   = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_src_pacer #(
        .DW       (DW),
        .HIGH_CYC (H),
        .GAP_CYC  (G)
    ) u_dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_out (data_out),
        .data_en  (data_en),
        .busy     (busy)
`ifdef MUX_SRC_PACER_ACK_EN
        ,
        .ack_in   (ack_in)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Timeline model: each accept opens an en window and a ready-again time.
    int            cyc        = 0;
    int            m_ready_at = 0;
    int            m_en_from  = 0;
    int            m_en_until = -1;
    logic [DW-1:0] m_data     = '0;
    bit            chk_en     = 1'b0;

    always @(posedge clk) begin
        if (!rstn) begin
            m_ready_at = cyc + 1;
            m_en_from  = 0;
            m_en_until = -1;
            m_data     = '0;
        end else if (in_valid && cyc >= m_ready_at) begin
            m_data     = in_data;
            m_en_from  = cyc + 1;
            m_en_until = cyc + H;
            m_ready_at = cyc + H + G + 1;
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_en",    32'(data_en),  32'(cyc >= m_en_from && cyc <= m_en_until));
            chk("model_ready", 32'(in_ready), 32'(cyc >= m_ready_at));
            chk("model_busy",  32'(busy),     32'(cyc < m_ready_at));
            chk("model_data",  32'(data_out), 32'(m_data));
        end
    end

    int   rise_q[$];
    logic en_prev = 1'b0;

    always @(negedge clk) begin
        if (data_en === 1'b1 && en_prev !== 1'b1) rise_q.push_back(cyc);
        en_prev = data_en;
    end

    initial begin
        int n_rise;

        // Reset held with a valid word present must not accept it.
        rstn     = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'hF;
        tick();
`ifndef MUX_SRC_PACER_ACK_EN
        chk_en = 1'b1;
`endif
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_data_en",  32'(data_en),  32'h0);
        tick();
        rstn     = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_busy",     32'(busy),     32'h0);
        tick();
        tick();

`ifndef MUX_SRC_PACER_ACK_EN
        // Single word, with ignored input during HIGH/LOW.
        in_valid = 1'b1;
        in_data  = 4'hA;
        tick();                                   // T+1
        in_valid = 1'b0;
        chk("sw_en_t1",   32'(data_en),  32'h1);
        chk("sw_data_t1", 32'(data_out), 32'hA);
        tick();                                   // T+2
        in_valid = 1'b1;
        in_data  = 4'h5;
        chk("sw_en_t2", 32'(data_en), 32'h1);
        tick();                                   // T+3
        chk("sw_en_t3",    32'(data_en),  32'h1);
        chk("sw_ready_t3", 32'(in_ready), 32'h0);
        tick();                                   // T+4
        chk("sw_en_t4", 32'(data_en), 32'h0);
        tick();                                   // T+5
        chk("ign_data_t5", 32'(data_out), 32'hA);
        tick();                                   // T+6
        chk("sw_en_t6",    32'(data_en),  32'h0);
        chk("sw_ready_t6", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        tick();                                   // T+7
        chk("sw_ready_t7", 32'(in_ready), 32'h1);
        chk("sw_data_t7",  32'(data_out), 32'hA);
        tick();

        // Streaming three words with in_valid held high.
        rise_q.delete();
        in_valid = 1'b1;
        in_data  = 4'h1;
        tick();                                   // T1+1
        chk("st_data_w1", 32'(data_out), 32'h1);
        in_data = 4'h2;
        repeat (6) tick();                        // T1+7
        chk("st_data_hold1", 32'(data_out), 32'h1);
        chk("st_ready_w2",   32'(in_ready), 32'h1);
        tick();                                   // T1+8
        chk("st_data_w2", 32'(data_out), 32'h2);
        in_data = 4'h3;
        repeat (7) tick();                        // T1+15
        chk("st_data_w3", 32'(data_out), 32'h3);
        in_valid = 1'b0;
        repeat (8) tick();
        chk("st_rise_count", 32'(rise_q.size()), 32'd3);
        if (rise_q.size() == 3) begin
            chk("st_spacing_12", 32'(rise_q[1] - rise_q[0]), 32'd7);
            chk("st_spacing_23", 32'(rise_q[2] - rise_q[1]), 32'd7);
        end

        // Reset during HIGH aborts the word.
        in_valid = 1'b1;
        in_data  = 4'h9;
        tick();                                   // T+1
        in_valid = 1'b0;
        tick();                                   // T+2
        rstn = 1'b0;
        tick();                                   // T+3, reset edge seen
        chk("mr_en",    32'(data_en),  32'h0);
        chk("mr_ready", 32'(in_ready), 32'h1);
        chk("mr_data",  32'(data_out), 32'h0);
        rstn   = 1'b1;
        n_rise = rise_q.size();
        repeat (6) tick();
        chk("mr_no_pulse", 32'(rise_q.size()), 32'(n_rise));
        chk("mr_en_after", 32'(data_en),       32'h0);
`else
        // Four-phase handshake with ack raised 10 cycles after accept.
        ack_in   = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'hA;
        tick();                                   // T+1
        in_valid = 1'b0;
        chk("ack_en_t1",   32'(data_en),  32'h1);
        chk("ack_data_t1", 32'(data_out), 32'hA);
        repeat (4) tick();                        // T+5
        chk("ack_en_t5", 32'(data_en), 32'h1);
        repeat (5) tick();                        // T+10
        ack_in = 1'b1;
        chk("ack_en_t10", 32'(data_en), 32'h1);
        tick();                                   // T+11
        chk("ack_en_t11", 32'(data_en), 32'h1);
        tick();                                   // T+12
        chk("ack_en_t12", 32'(data_en), 32'h1);
        tick();                                   // T+13
        chk("ack_en_t13",    32'(data_en),  32'h0);
        chk("ack_ready_t13", 32'(in_ready), 32'h0);
        repeat (3) tick();                        // T+16
        chk("ack_ready_t16", 32'(in_ready), 32'h0);
        repeat (4) tick();                        // T+20
        ack_in = 1'b0;
        tick();                                   // T+21
        chk("ack_ready_t21", 32'(in_ready), 32'h0);
        tick();                                   // T+22
        chk("ack_ready_t22", 32'(in_ready), 32'h0);
        tick();                                   // T+23
        chk("ack_ready_t23", 32'(in_ready), 32'h1);
        chk("ack_busy_t23",  32'(busy),     32'h0);
        chk("ack_data_t23",  32'(data_out), 32'hA);
`endif

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
